// File: rtl/l1_beat_bridge.sv
// Splits a cache-line memory request into bus beats, one transaction at a time,
// and reassembles read beats into a single one-cycle line response.
module l1_beat_bridge #(
   parameter int LINE_BITS = 256,
   parameter int BEAT_BITS = 64,
   parameter int ADDR_BITS = 48
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_req_mem_valid,
   output logic                     o_req_mem_ready,
   input  logic                     i_req_mem_path,
   input  logic [1:0]               i_req_mem_type,
   input  logic [2:0]               i_req_mem_size,
   input  logic [ADDR_BITS-1:0]     i_req_mem_addr,
   input  logic [LINE_BITS/8-1:0]   i_req_mem_strob,
   input  logic [LINE_BITS-1:0]     i_req_mem_data,
   output logic                     o_bus_req_valid,
   input  logic                     i_bus_req_ready,
   output logic                     o_bus_req_write,
   output logic [ADDR_BITS-1:0]     o_bus_req_addr,
   output logic [BEAT_BITS-1:0]     o_bus_req_wdata,
   output logic [BEAT_BITS/8-1:0]   o_bus_req_wstrb,
   input  logic                     i_bus_resp_valid,
   input  logic [BEAT_BITS-1:0]     i_bus_resp_rdata,
   input  logic                     i_bus_resp_err,
   output logic                     o_resp_mem_valid,
   output logic                     o_resp_mem_path,
   output logic [LINE_BITS-1:0]     o_resp_mem_data,
   output logic                     o_resp_mem_load_fault,
   output logic                     o_resp_mem_store_fault
);
   localparam int BEATS      = LINE_BITS / BEAT_BITS;
   localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int BEAT_BYTES = BEAT_BITS / 8;
   localparam int BOFF       = $clog2(BEAT_BYTES);
   localparam int LOFF       = $clog2(LINE_BITS / 8);
   localparam logic [ADDR_BITS-1:0] LINE_MASK = {ADDR_BITS{1'b1}} << LOFF;
   localparam logic [ADDR_BITS-1:0] BEAT_MASK = {ADDR_BITS{1'b1}} << BOFF;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t                  state_q, state_d;
   logic                    path_q, write_q, cached_q, err_q;
   logic [ADDR_BITS-1:0]    addr_q;
   logic [LINE_BITS/8-1:0]  strob_q;
   logic [LINE_BITS-1:0]    data_q, line_q;
   logic [CNT_W-1:0]        beat_q, lane, slot;
   logic                    last_beat;
   logic [ADDR_BITS-1:0]    beat_addr;
   logic                    unused_size;

   assign unused_size = ^i_req_mem_size;

   // Uncached requests use the single beat lane that holds the addressed bytes.
   assign lane      = CNT_W'(addr_q >> BOFF);
   assign slot      = cached_q ? beat_q : lane;
   assign last_beat = !cached_q || (beat_q == CNT_W'(BEATS - 1));
   assign beat_addr = cached_q ? ((addr_q & LINE_MASK) + (ADDR_BITS'(beat_q) << BOFF))
                               : (addr_q & BEAT_MASK);

   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (i_req_mem_valid)  state_d = REQ;
         REQ:  if (i_bus_req_ready)  state_d = WAIT;
         WAIT: if (i_bus_resp_valid) state_d = last_beat ? RESP : REQ;
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         path_q   <= 1'b0;
         write_q  <= 1'b0;
         cached_q <= 1'b0;
         err_q    <= 1'b0;
         addr_q   <= '0;
         strob_q  <= '0;
         data_q   <= '0;
         line_q   <= '0;
         beat_q   <= '0;
      end else if (state_q == IDLE && i_req_mem_valid) begin
         path_q   <= i_req_mem_path;
         write_q  <= i_req_mem_type[0];
         cached_q <= i_req_mem_type[1];
         addr_q   <= i_req_mem_addr;
         strob_q  <= i_req_mem_strob;
         data_q   <= i_req_mem_data;
         err_q    <= 1'b0;
         line_q   <= '0;
         beat_q   <= '0;
      end else if (state_q == WAIT && i_bus_resp_valid) begin
         // Errors accumulate but never cut the beat sequence short.
         if (!write_q) line_q[int'(slot)*BEAT_BITS +: BEAT_BITS] <= i_bus_resp_rdata;
         err_q <= err_q | i_bus_resp_err;
         if (!last_beat) beat_q <= beat_q + CNT_W'(1);
      end
   end

   always_comb begin
      o_req_mem_ready        = 1'b0;
      o_bus_req_valid        = 1'b0;
      o_bus_req_write        = 1'b0;
      o_bus_req_addr         = '0;
      o_bus_req_wdata        = '0;
      o_bus_req_wstrb        = '0;
      o_resp_mem_valid       = 1'b0;
      o_resp_mem_path        = 1'b0;
      o_resp_mem_data        = '0;
      o_resp_mem_load_fault  = 1'b0;
      o_resp_mem_store_fault = 1'b0;
      case (state_q)
         IDLE: o_req_mem_ready = 1'b1;
         REQ: begin
            o_bus_req_valid = 1'b1;
            o_bus_req_write = write_q;
            o_bus_req_addr  = beat_addr;
            o_bus_req_wdata = data_q[int'(slot)*BEAT_BITS +: BEAT_BITS];
            o_bus_req_wstrb = strob_q[int'(slot)*BEAT_BYTES +: BEAT_BYTES];
         end
         RESP: begin
            o_resp_mem_valid       = 1'b1;
            o_resp_mem_path        = path_q;
            o_resp_mem_data        = line_q;
            o_resp_mem_load_fault  = err_q & !write_q;
            o_resp_mem_store_fault = err_q & write_q;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_l1_beat_bridge.sv
// Directed bench for l1_beat_bridge: a small bus responder answers every beat
// one cycle after its handshake, and each scenario checks hand-computed results.
module tb_l1_beat_bridge;
   localparam int LINE_BITS = 256;
   localparam int BEAT_BITS = 64;
   localparam int ADDR_BITS = 48;

   logic                    i_clk = 1'b0;
   logic                    i_rst;
   logic                    i_req_mem_valid;
   logic                    o_req_mem_ready;
   logic                    i_req_mem_path;
   logic [1:0]              i_req_mem_type;
   logic [2:0]              i_req_mem_size;
   logic [ADDR_BITS-1:0]    i_req_mem_addr;
   logic [LINE_BITS/8-1:0]  i_req_mem_strob;
   logic [LINE_BITS-1:0]    i_req_mem_data;
   logic                    o_bus_req_valid;
   logic                    i_bus_req_ready;
   logic                    o_bus_req_write;
   logic [ADDR_BITS-1:0]    o_bus_req_addr;
   logic [BEAT_BITS-1:0]    o_bus_req_wdata;
   logic [BEAT_BITS/8-1:0]  o_bus_req_wstrb;
   logic                    i_bus_resp_valid;
   logic [BEAT_BITS-1:0]    i_bus_resp_rdata;
   logic                    i_bus_resp_err;
   logic                    o_resp_mem_valid;
   logic                    o_resp_mem_path;
   logic [LINE_BITS-1:0]    o_resp_mem_data;
   logic                    o_resp_mem_load_fault;
   logic                    o_resp_mem_store_fault;

   always #5 i_clk = ~i_clk;

   l1_beat_bridge #(.LINE_BITS(LINE_BITS), .BEAT_BITS(BEAT_BITS), .ADDR_BITS(ADDR_BITS)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req_mem_valid(i_req_mem_valid), .o_req_mem_ready(o_req_mem_ready),
      .i_req_mem_path(i_req_mem_path), .i_req_mem_type(i_req_mem_type),
      .i_req_mem_size(i_req_mem_size), .i_req_mem_addr(i_req_mem_addr),
      .i_req_mem_strob(i_req_mem_strob), .i_req_mem_data(i_req_mem_data),
      .o_bus_req_valid(o_bus_req_valid), .i_bus_req_ready(i_bus_req_ready),
      .o_bus_req_write(o_bus_req_write), .o_bus_req_addr(o_bus_req_addr),
      .o_bus_req_wdata(o_bus_req_wdata), .o_bus_req_wstrb(o_bus_req_wstrb),
      .i_bus_resp_valid(i_bus_resp_valid), .i_bus_resp_rdata(i_bus_resp_rdata),
      .i_bus_resp_err(i_bus_resp_err),
      .o_resp_mem_valid(o_resp_mem_valid), .o_resp_mem_path(o_resp_mem_path),
      .o_resp_mem_data(o_resp_mem_data), .o_resp_mem_load_fault(o_resp_mem_load_fault),
      .o_resp_mem_store_fault(o_resp_mem_store_fault)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Responder configuration, written only by the stimulus process.
   int                   err_beat   = -1;
   int                   rsp_limit  = 99;
   int                   stall_cfg  = 0;
   logic [63:0]          rdata_base = '0;
   logic                 force_resp = 1'b0;
   logic                 force_err  = 1'b0;

   // Responder state, written only by the responder process.
   logic                 pend = 1'b0;
   int                   pend_idx = 0;
   int                   beat_n = 0;
   int                   stall_seen = 0;
   int                   stall_moved = 0;
   logic [ADDR_BITS-1:0] stall_addr = '0;
   logic [ADDR_BITS-1:0] log_addr  [8];
   logic [63:0]          log_wdata [8];
   logic [7:0]           log_wstrb [8];
   logic                 log_write [8];

   // Answers each accepted beat on the following cycle; rdata is base + beat index.
   always @(negedge i_clk) begin
      i_bus_resp_valid = force_resp || (pend && pend_idx < rsp_limit);
      i_bus_resp_rdata = rdata_base + 64'(pend_idx);
      i_bus_resp_err   = force_err || (pend && pend_idx == err_beat);
      pend = 1'b0;
      if (o_req_mem_ready) begin
         beat_n      = 0;
         stall_seen  = 0;
         stall_moved = 0;
      end
      if (o_bus_req_valid && stall_seen < stall_cfg) begin
         if (stall_seen == 0) stall_addr = o_bus_req_addr;
         else if (o_bus_req_addr != stall_addr) stall_moved++;
         stall_seen++;
         i_bus_req_ready = 1'b0;
      end else begin
         i_bus_req_ready = 1'b1;
      end
      if (o_bus_req_valid && i_bus_req_ready) begin
         if (stall_seen > 0 && beat_n == 0 && o_bus_req_addr != stall_addr) stall_moved++;
         if (beat_n < 8) begin
            log_addr[beat_n]  = o_bus_req_addr;
            log_wdata[beat_n] = o_bus_req_wdata;
            log_wstrb[beat_n] = o_bus_req_wstrb;
            log_write[beat_n] = o_bus_req_write;
         end
         pend     = 1'b1;
         pend_idx = beat_n;
         beat_n++;
      end
   end

   int                   accept_cyc, resp_cyc, busy_ready_seen;
   logic                 got_resp, r_path, r_lf, r_sf;
   logic [LINE_BITS-1:0] r_data;
   logic                 busy_hold = 1'b0;
   logic [ADDR_BITS-1:0] busy_addr = '0;
   logic [1:0]           busy_type = '0;

   task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic startReq(input logic path, input logic [1:0] typ, input logic [ADDR_BITS-1:0] addr,
                           input logic [31:0] strob, input logic [LINE_BITS-1:0] data);
      int n = 0;
      @(negedge i_clk);
      i_req_mem_valid = 1'b1;
      i_req_mem_path  = path;
      i_req_mem_type  = typ;
      i_req_mem_size  = typ[1] ? 3'd5 : 3'd3;
      i_req_mem_addr  = addr;
      i_req_mem_strob = strob;
      i_req_mem_data  = data;
      #1;
      while (!o_req_mem_ready && n < 50) begin
         @(negedge i_clk);
         #1;
         n++;
      end
      checkOutput("accept", o_req_mem_ready, 1);
      accept_cyc = cyc;
      @(posedge i_clk);
      #1;
      if (busy_hold) begin
         i_req_mem_addr = busy_addr;
         i_req_mem_type = busy_type;
      end else begin
         i_req_mem_valid = 1'b0;
      end
   endtask

   task automatic waitResp();
      int n = 0;
      got_resp = 1'b0;
      busy_ready_seen = 0;
      while (n < 200) begin
         @(negedge i_clk);
         #1;
         if (o_resp_mem_valid) begin
            got_resp = 1'b1;
            resp_cyc = cyc;
            r_path   = o_resp_mem_path;
            r_data   = o_resp_mem_data;
            r_lf     = o_resp_mem_load_fault;
            r_sf     = o_resp_mem_store_fault;
            break;
         end
         if (o_req_mem_ready) busy_ready_seen++;
         n++;
      end
      checkOutput("resp_seen", got_resp, 1);
   endtask

   task automatic applyStimulus(input logic path, input logic [1:0] typ, input logic [ADDR_BITS-1:0] addr,
                                input logic [31:0] strob, input logic [LINE_BITS-1:0] data);
      startReq(path, typ, addr, strob, data);
      waitResp();
   endtask

   localparam logic [LINE_BITS-1:0] WLINE = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};

   initial begin
      int pulses;
      int n;
      i_rst = 1'b1;
      i_req_mem_valid = 1'b0;
      i_req_mem_path  = 1'b0;
      i_req_mem_type  = '0;
      i_req_mem_size  = '0;
      i_req_mem_addr  = '0;
      i_req_mem_strob = '0;
      i_req_mem_data  = '0;
      repeat (3) @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      checkOutput("rst_ready", o_req_mem_ready, 1);
      checkOutput("rst_bus_valid", o_bus_req_valid, 0);
      checkOutput("rst_resp_valid", o_resp_mem_valid, 0);
      checkOutput("rst_bus_addr", o_bus_req_addr, 0);

      // Cached read at 0x1010.
      applyStimulus(1'b0, 2'b10, 48'h1010, 32'h0, '0);
      checkOutput("cr_beats", beat_n, 4);
      checkOutput("cr_addr0", log_addr[0], 48'h1000);
      checkOutput("cr_addr1", log_addr[1], 48'h1008);
      checkOutput("cr_addr2", log_addr[2], 48'h1010);
      checkOutput("cr_addr3", log_addr[3], 48'h1018);
      checkOutput("cr_write", log_write[2], 0);
      checkOutput("cr_data", r_data, {64'd3, 64'd2, 64'd1, 64'd0});
      checkOutput("cr_faults", {r_lf, r_sf}, 0);
      checkOutput("cr_latency", resp_cyc - accept_cyc + 1, 10);

      // Uncached write at 0x2014 lands on lane 2.
      applyStimulus(1'b1, 2'b01, 48'h2014, 32'h00F0_0000, WLINE);
      checkOutput("uw_beats", beat_n, 1);
      checkOutput("uw_addr", log_addr[0], 48'h2010);
      checkOutput("uw_wstrb", log_wstrb[0], 8'hF0);
      checkOutput("uw_wdata", log_wdata[0], 64'hCCCC_CCCC_CCCC_CCCC);
      checkOutput("uw_write", log_write[0], 1);
      checkOutput("uw_path", r_path, 1);
      checkOutput("uw_sf", r_sf, 0);
      checkOutput("uw_data", r_data, 0);
      checkOutput("uw_latency", resp_cyc - accept_cyc + 1, 4);

      // Cached write with an error on beat 2 only.
      err_beat = 2;
      applyStimulus(1'b0, 2'b11, 48'h3040, 32'h8040_2010, WLINE);
      err_beat = -1;
      checkOutput("cw_beats", beat_n, 4);
      checkOutput("cw_addr3", log_addr[3], 48'h3058);
      checkOutput("cw_wstrb1", log_wstrb[1], 8'h20);
      checkOutput("cw_wdata2", log_wdata[2], 64'hCCCC_CCCC_CCCC_CCCC);
      checkOutput("cw_sf", r_sf, 1);
      checkOutput("cw_lf", r_lf, 0);
      checkOutput("cw_data", r_data, 0);

      // Bus stalls the first beat for 5 cycles; read error on beat 0.
      stall_cfg = 5;
      err_beat  = 0;
      applyStimulus(1'b0, 2'b10, 48'h6000, 32'h0, '0);
      stall_cfg = 0;
      err_beat  = -1;
      checkOutput("st_stalls", stall_seen, 5);
      checkOutput("st_moved", stall_moved, 0);
      checkOutput("st_addr0", log_addr[0], 48'h6000);
      checkOutput("st_latency", resp_cyc - accept_cyc + 1, 15);
      checkOutput("st_lf", r_lf, 1);
      checkOutput("st_sf", r_sf, 0);

      // Reset while waiting on beat 1, followed by a late bus response.
      rsp_limit = 1;
      startReq(1'b1, 2'b10, 48'h7000, 32'h0, '0);
      n = 0;
      while (!(beat_n == 2 && !o_bus_req_valid) && n < 50) begin
         @(negedge i_clk);
         #1;
         n++;
      end
      checkOutput("rs_in_wait", beat_n, 2);
      checkOutput("rs_addr1", log_addr[1], 48'h7008);
      @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      checkOutput("rs_ready", o_req_mem_ready, 1);
      checkOutput("rs_bus_valid", o_bus_req_valid, 0);
      force_resp = 1'b1;
      force_err  = 1'b1;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge i_clk);
         #1;
         if (i == 2) begin
            force_resp = 1'b0;
            force_err  = 1'b0;
         end
         if (o_resp_mem_valid) pulses++;
      end
      rsp_limit = 99;
      checkOutput("rs_no_pulse", pulses, 0);
      checkOutput("rs_idle_ready", o_req_mem_ready, 1);
      rdata_base = 64'h55;
      applyStimulus(1'b0, 2'b00, 48'h7018, 32'h0, '0);
      checkOutput("rs_next_addr", log_addr[0], 48'h7018);
      checkOutput("rs_next_data", r_data, {64'h55, 192'h0});
      checkOutput("rs_next_lf", r_lf, 0);

      // A second request held while busy waits until the RESP cycle has passed.
      rdata_base = 64'h100;
      busy_hold  = 1'b1;
      busy_addr  = 48'h5008;
      busy_type  = 2'b00;
      applyStimulus(1'b0, 2'b10, 48'h4000, 32'h0, '0);
      busy_hold = 1'b0;
      checkOutput("bz_ready_busy", busy_ready_seen, 0);
      checkOutput("bz_data", r_data, {64'h103, 64'h102, 64'h101, 64'h100});
      n = resp_cyc;
      applyStimulus(1'b0, 2'b00, 48'h5008, 32'h0, '0);
      checkOutput("bz_accept_cyc", accept_cyc, n + 1);
      checkOutput("bz_addr", log_addr[0], 48'h5008);
      checkOutput("bz_data2", r_data, {128'h0, 64'h100, 64'h0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
